decode_stage: RTL and testbench

Registered, WIDTH-lane instruction decode stage for the out-of-order RV32I core. It sits between fetch and rename. Each cycle it accepts a bundle of up to WIDTH instructions with their PCs and decodes them into per-lane control fields. It squashes NOPs per lane and flags illegal encodings. Results are held in a 2-entry skid buffer behind a valid/ready handshake, so a rename back-pressure never drops a bundle.

---
 rtl/decode_pkg.sv | 72 +++++++
 rtl/decode_lane.sv | 102 ++++++++++
 rtl/decode_stage.sv | 105 ++++++++++
 tb/tb_decode_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcodes, sub-op codes and decoded-lane types for decode_stage
package decode_pkg;

    localparam int MAX_LANES = 4;
    localparam int PC_MAX    = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_SLTU  = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_LUI   = 4'b1000;
    localparam logic [3:0] ALU_AUIPC = 4'b1001;
    localparam logic [3:0] ALU_OR    = 4'b1010;
    localparam logic [3:0] ALU_AND   = 4'b1011;
    localparam logic [3:0] ALU_JAL   = 4'b1100;
    localparam logic [3:0] ALU_JALR  = 4'b1101;

    localparam logic [1:0] FU_ALU    = 2'b00;
    localparam logic [1:0] FU_BR     = 2'b01;
    localparam logic [1:0] FU_LSU    = 2'b10;
    localparam logic [1:0] FU_MULDIV = 2'b11;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic              live;
        logic              illegal;
        logic [PC_MAX-1:0] pc;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [31:0]       imm;
        logic [3:0]        alu_op;
        logic [1:0]        fu_type;
        logic              alu_src;
        logic              branch;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
    } decoded_t;

    typedef decoded_t [MAX_LANES-1:0] bundle_t;

    // alt selects SUB/SRA over ADD/SRL
    function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_code = ALU_SLL;
            3'b010:  alu_code = ALU_SLT;
            3'b011:  alu_code = ALU_SLTU;
            3'b100:  alu_code = ALU_XOR;
            3'b101:  alu_code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_code = ALU_OR;
            default: alu_code = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_lane.sv
// rtl/decode_lane.sv - combinational single-lane RV32I decode; DECODE_MULDIV_EN adds M-extension
module decode_lane
    import decode_pkg::*;
(
    input  logic [31:0]       instr,
    input  logic [PC_MAX-1:0] pc,
    input  logic              en,
    output decoded_t          dec
);

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic       shift, ill;
    decoded_t   d;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign shift  = (f3 == 3'b001) || (f3 == 3'b101);
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        d      = '0;
        ill    = 1'b0;
        case (opcode)
            OP_REG: begin
                if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    d.rs1 = instr[19:15]; d.rs2 = instr[24:20]; d.rd = instr[11:7];
                    d.alu_op = alu_code(f3, f7[5]); d.reg_write = 1'b1;
                end
`ifdef DECODE_MULDIV_EN
                else if (f7 == 7'b0000001) begin
                    d.rs1 = instr[19:15]; d.rs2 = instr[24:20]; d.rd = instr[11:7];
                    d.alu_op = {1'b0, f3}; d.fu_type = FU_MULDIV; d.reg_write = 1'b1;
                end
`endif
                else ill = 1'b1;
            end
            OP_IMM: begin
                // funct7 only qualifies the shift forms; elsewhere those bits are immediate
                if (shift && !(f7 == 7'b0000000 || (f3 == 3'b101 && f7 == 7'b0100000))) ill = 1'b1;
                else begin
                    d.rs1 = instr[19:15]; d.rd = instr[11:7]; d.imm = imm_i;
                    d.alu_op = alu_code(f3, shift && f7[5]); d.alu_src = 1'b1; d.reg_write = 1'b1;
                end
            end
            OP_LOAD: begin
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
                else begin
                    d.rs1 = instr[19:15]; d.rd = instr[11:7]; d.imm = imm_i; d.alu_op = {1'b0, f3};
                    d.fu_type = FU_LSU; d.alu_src = 1'b1; d.mem_read = 1'b1; d.reg_write = 1'b1;
                end
            end
            OP_STORE: begin
                if (f3[2] || f3 == 3'b011) ill = 1'b1;
                else begin
                    d.rs1 = instr[19:15]; d.rs2 = instr[24:20]; d.imm = imm_s; d.alu_op = {1'b0, f3};
                    d.fu_type = FU_LSU; d.alu_src = 1'b1; d.mem_write = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
                else begin
                    d.rs1 = instr[19:15]; d.rs2 = instr[24:20]; d.imm = imm_b; d.alu_op = {1'b0, f3};
                    d.fu_type = FU_BR; d.branch = 1'b1;
                end
            end
            OP_LUI: begin
                d.rd = instr[11:7]; d.imm = imm_u; d.alu_op = ALU_LUI; d.alu_src = 1'b1; d.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                d.rd = instr[11:7]; d.imm = imm_u; d.alu_op = ALU_AUIPC; d.alu_src = 1'b1; d.reg_write = 1'b1;
            end
            OP_JAL: begin
                d.rd = instr[11:7]; d.imm = imm_j; d.alu_op = ALU_JAL; d.fu_type = FU_BR;
                d.branch = 1'b1; d.reg_write = 1'b1;
            end
            OP_JALR: begin
                if (f3 != 3'b000) ill = 1'b1;
                else begin
                    d.rs1 = instr[19:15]; d.rd = instr[11:7]; d.imm = imm_i; d.alu_op = ALU_JALR;
                    d.fu_type = FU_BR; d.alu_src = 1'b1; d.branch = 1'b1; d.reg_write = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase
        if (ill) d = '0;
        d.illegal = ill;
        if (d.rd == 5'd0) d.reg_write = 1'b0;
        d.pc   = pc;
        d.live = en && (instr != NOP);
        if (!d.live) d = '0;
    end

    assign dec = d;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - WIDTH-lane registered decode with 2-entry skid buffer; DECODE_MULDIV_EN enables M-extension decode
module decode_stage
    import decode_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int PC_W  = 9
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0][31:0]     in_instr,
    input  logic [WIDTH-1:0][PC_W-1:0] in_pc,
    input  logic [WIDTH-1:0]           in_lane_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_lane_valid,
    output logic [WIDTH-1:0][PC_W-1:0] out_pc,
    output logic [WIDTH-1:0][4:0]      out_rs1,
    output logic [WIDTH-1:0][4:0]      out_rs2,
    output logic [WIDTH-1:0][4:0]      out_rd,
    output logic [WIDTH-1:0][31:0]     out_imm,
    output logic [WIDTH-1:0][3:0]      out_alu_op,
    output logic [WIDTH-1:0][1:0]      out_fu_type,
    output logic [WIDTH-1:0]           out_alu_src,
    output logic [WIDTH-1:0]           out_branch,
    output logic [WIDTH-1:0]           out_mem_read,
    output logic [WIDTH-1:0]           out_mem_write,
    output logic [WIDTH-1:0]           out_reg_write,
    output logic [WIDTH-1:0]           out_illegal
);

    bundle_t dec_bundle, main_q, skid_q, head;
    logic    main_v, skid_v, any_live, enq, pop;

    for (genvar k = 0; k < MAX_LANES; k++) begin : g_lane
        if (k < WIDTH) begin : g_used
            decode_lane u_lane (
                .instr (in_instr[k]),
                .pc    (PC_MAX'(in_pc[k])),
                .en    (in_lane_en[k]),
                .dec   (dec_bundle[k])
            );
        end else begin : g_unused
            assign dec_bundle[k] = '0;
        end
    end

    always_comb begin
        any_live = 1'b0;
        for (int k = 0; k < MAX_LANES; k++) any_live = any_live | dec_bundle[k].live;
    end

    // in_ready depends only on registered state, so rename back-pressure never reaches fetch combinationally
    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign pop       = main_v && out_ready;
    assign enq       = in_valid && in_ready && any_live;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (!main_v || pop) begin
            if (skid_v) begin
                main_q <= skid_q;
                skid_v <= 1'b0;
            end else begin
                main_v <= enq;
                if (enq) main_q <= dec_bundle;
            end
        end else if (enq) begin
            skid_q <= dec_bundle;
            skid_v <= 1'b1;
        end
    end

    assign head = main_v ? main_q : '0;

    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            out_lane_valid[k] = head[k].live;
            out_pc[k]         = head[k].pc[PC_W-1:0];
            out_rs1[k]        = head[k].rs1;
            out_rs2[k]        = head[k].rs2;
            out_rd[k]         = head[k].rd;
            out_imm[k]        = head[k].imm;
            out_alu_op[k]     = head[k].alu_op;
            out_fu_type[k]    = head[k].fu_type;
            out_alu_src[k]    = head[k].alu_src;
            out_branch[k]     = head[k].branch;
            out_mem_read[k]   = head[k].mem_read;
            out_mem_write[k]  = head[k].mem_write;
            out_reg_write[k]  = head[k].reg_write;
            out_illegal[k]    = head[k].illegal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed-vector bench for decode_stage (WIDTH=2, PC_W=9)
module tb_decode_stage;

    localparam int W  = 2;
    localparam int PW = 9;

    logic              clk = 1'b0;
    logic              reset_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0][31:0] in_instr;
    logic [W-1:0][PW-1:0] in_pc;
    logic [W-1:0]      in_lane_en;
    logic [W-1:0]      out_lane_valid, out_alu_src, out_branch, out_mem_read;
    logic [W-1:0]      out_mem_write, out_reg_write, out_illegal;
    logic [W-1:0][PW-1:0] out_pc;
    logic [W-1:0][4:0] out_rs1, out_rs2, out_rd;
    logic [W-1:0][31:0] out_imm;
    logic [W-1:0][3:0] out_alu_op;
    logic [W-1:0][1:0] out_fu_type;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    decode_stage #(.WIDTH(W), .PC_W(PW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_lane_en(in_lane_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane_valid(out_lane_valid),
        .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_alu_op(out_alu_op), .out_fu_type(out_fu_type),
        .out_alu_src(out_alu_src), .out_branch(out_branch), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_reg_write(out_reg_write), .out_illegal(out_illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [PW-1:0] p0, input logic [PW-1:0] p1, input logic [1:0] en);
        in_valid    = v;
        in_instr[0] = i0;
        in_instr[1] = i1;
        in_pc[0]    = p0;
        in_pc[1]    = p1;
        in_lane_en  = en;
    endtask

    function automatic logic [31:0] addi_k(input int k);
        addi_k = {12'(k), 5'd0, 3'b000, 5'(k), 7'b0010011};
    endfunction

    initial begin
        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 9'h0, 9'h0, 2'b00);
        step(); step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_lane_valid", 64'(out_lane_valid), 64'd0);
        check("rst_imm", 64'(out_imm), 64'd0);
        reset_n = 1'b1;
        step();

        // add x3,x1,x2 ; addi x5,x0,-1
        drive(1'b1, 32'h002081B3, 32'hFFF00293, 9'h10, 9'h14, 2'b11);
        step();
        drive(1'b0, 32'h0, 32'h0, 9'h0, 9'h0, 2'b00);
        check("a_valid", 64'(out_valid), 64'd1);
        check("a_lanes", 64'(out_lane_valid), 64'h3);
        check("a_rs1_0", 64'(out_rs1[0]), 64'd1);
        check("a_rs2_0", 64'(out_rs2[0]), 64'd2);
        check("a_rd_0", 64'(out_rd[0]), 64'd3);
        check("a_aluop_0", 64'(out_alu_op[0]), 64'h0);
        check("a_rw_0", 64'(out_reg_write[0]), 64'd1);
        check("a_imm_1", 64'(out_imm[1]), 64'hFFFF_FFFF);
        check("a_alusrc_1", 64'(out_alu_src[1]), 64'd1);
        check("a_rd_1", 64'(out_rd[1]), 64'd5);
        check("a_pc_1", 64'(out_pc[1]), 64'h14);
        step();
        check("a_drained", 64'(out_valid), 64'd0);

        // nop ; lw x4,8(x2)
        drive(1'b1, 32'h00000013, 32'h00812203, 9'h20, 9'h24, 2'b11);
        step();
        drive(1'b0, 32'h0, 32'h0, 9'h0, 9'h0, 2'b00);
        check("b_lanes", 64'(out_lane_valid), 64'h2);
        check("b_pc_0", 64'(out_pc[0]), 64'd0);
        check("b_rd_0", 64'(out_rd[0]), 64'd0);
        check("b_fu_1", 64'(out_fu_type[1]), 64'd2);
        check("b_mrd_1", 64'(out_mem_read[1]), 64'd1);
        check("b_imm_1", 64'(out_imm[1]), 64'd8);
        check("b_aluop_1", 64'(out_alu_op[1]), 64'h2);
        check("b_rs1_1", 64'(out_rs1[1]), 64'd2);
        step();

        // a bundle with no live lanes is consumed but never appears
        drive(1'b1, 32'h00000013, 32'h002081B3, 9'h30, 9'h34, 2'b01);
        step();
        drive(1'b0, 32'h0, 32'h0, 9'h0, 9'h0, 2'b00);
        check("dead_not_enq", 64'(out_valid), 64'd0);
        check("dead_ready", 64'(in_ready), 64'd1);

        // sub x6,x1,x2 ; beq x1,x2,+8
        drive(1'b1, 32'h40208333, 32'h00208463, 9'h40, 9'h44, 2'b11);
        step();
        drive(1'b0, 32'h0, 32'h0, 9'h0, 9'h0, 2'b00);
        check("c_sub_op", 64'(out_alu_op[0]), 64'h1);
        check("c_br_bits", {60'd0, out_branch[1], out_reg_write[1], out_fu_type[1]}, 64'b1001);
        check("c_br_imm", 64'(out_imm[1]), 64'd8);
        step();

        // back-pressure: three bundles offered, two buffered, then drained in order
        out_ready = 1'b0;
        drive(1'b1, addi_k(1), 32'h0, 9'h1, 9'h0, 2'b01);
        step();
        check("bp1_ready", 64'(in_ready), 64'd1);
        check("bp1_imm", 64'(out_imm[0]), 64'd1);
        drive(1'b1, addi_k(2), 32'h0, 9'h2, 9'h0, 2'b01);
        step();
        check("bp2_ready", 64'(in_ready), 64'd0);
        drive(1'b1, addi_k(3), 32'h0, 9'h3, 9'h0, 2'b01);
        step();
        check("bp3_ready", 64'(in_ready), 64'd0);
        check("bp3_stable", 64'(out_imm[0]), 64'd1);
        out_ready = 1'b1;
        step();
        check("bp_pop1_imm", 64'(out_imm[0]), 64'd2);
        check("bp_pop1_ready", 64'(in_ready), 64'd1);
        step();
        drive(1'b0, 32'h0, 32'h0, 9'h0, 9'h0, 2'b00);
        check("bp_pop2_imm", 64'(out_imm[0]), 64'd3);
        check("bp_pop2_ready", 64'(in_ready), 64'd1);
        step();
        check("bp_empty", 64'(out_valid), 64'd0);

        // flush with both entries full and a bundle offered
        out_ready = 1'b0;
        drive(1'b1, addi_k(4), 32'h0, 9'h4, 9'h0, 2'b01);
        step();
        drive(1'b1, addi_k(5), 32'h0, 9'h5, 9'h0, 2'b01);
        step();
        check("fl_full", 64'(in_ready), 64'd0);
        drive(1'b1, addi_k(6), 32'h0, 9'h6, 9'h0, 2'b01);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 9'h0, 9'h0, 2'b00);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready), 64'd1);
        step();
        check("fl_absent", 64'(out_valid), 64'd0);

        // flush wins over a same-cycle accept with one entry held
        drive(1'b1, addi_k(7), 32'h0, 9'h7, 9'h0, 2'b01);
        step();
        drive(1'b1, addi_k(8), 32'h0, 9'h8, 9'h0, 2'b01);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 9'h0, 9'h0, 2'b00);
        step();
        check("fl_acc_drop", 64'(out_valid), 64'd0);
        out_ready = 1'b1;

        // mul x1,x2,x3 ; all-ones word is an illegal opcode
        drive(1'b1, 32'h023100B3, 32'hFFFFFFFF, 9'h50, 9'h54, 2'b11);
        step();
        drive(1'b0, 32'h0, 32'h0, 9'h0, 9'h0, 2'b00);
`ifdef DECODE_MULDIV_EN
        check("mul_fu", 64'(out_fu_type[0]), 64'd3);
        check("mul_op", 64'(out_alu_op[0]), 64'h0);
        check("mul_rw_ill", {62'd0, out_reg_write[0], out_illegal[0]}, 64'b10);
`else
        check("mul_ill", 64'(out_illegal[0]), 64'd1);
        check("mul_rw", 64'(out_reg_write[0]), 64'd0);
        check("mul_fu", 64'(out_fu_type[0]), 64'd0);
`endif
        check("ill_live", {62'd0, out_lane_valid[1], out_illegal[1]}, 64'b11);
        step();

        // asynchronous reset mid-cycle with the buffer full
        out_ready = 1'b0;
        drive(1'b1, addi_k(9), 32'h0, 9'h9, 9'h0, 2'b01);
        step();
        drive(1'b1, addi_k(10), 32'h0, 9'ha, 9'h0, 2'b01);
        step();
        drive(1'b0, 32'h0, 32'h0, 9'h0, 9'h0, 2'b00);
        check("ar_full", 64'(in_ready), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_ready", 64'(in_ready), 64'd1);
        check("ar_imm", 64'(out_imm), 64'd0);
        check("ar_pc", 64'(out_pc), 64'd0);
        step();
        reset_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
